seqgen_52: RTL and testbench

Serial pattern transmitter: the source end of the single-bit serial stream consumed by the `seqdec_52` sequence detector. On a start request it shifts a stored WIDTH-bit pattern out on one wire, MSB first (oldest bit first), one bit per clock. It is used to drive detector benches and as the stimulus generator in the serial datapath. The pattern register resets to 8'h52, the sequence 0,1,0,1,0,0,1,0 in transmission order. It can be reloaded at run time.

---
 rtl/seqgen_52.sv | 133 +++++++++++++
 tb/tb_seqgen_52.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seqgen_52.sv
// -----------------------------------------------------------------------------
// seqgen_52 -- serial pattern transmitter
//
// Shifts a stored WIDTH-bit pattern out on a single wire, MSB first, one bit
// per clock, whenever a frame is requested. Frames can be chained back to
// back with no idle gap. The pattern register can be rewritten at any time
// without disturbing a frame already in flight.
//
// Parameters
//   WIDTH   : pattern length in bits (>= 2)
//   PATTERN : reset value of the pattern register
//
// Ports
//   clk_i   : clock, all state updates on the rising edge
//   rst_ni  : asynchronous active-low reset
//   start_i : frame request
//   load_i  : pattern register write enable
//   din_i   : new pattern value, captured when load_i=1
//   out_o   : serial data (registered, idles at 0)
//   busy_o  : high while a frame is on out_o (registered)
//   done_o  : one-cycle pulse after the last bit of a frame (registered)
// -----------------------------------------------------------------------------
module seqgen_52 #(
  parameter int unsigned             WIDTH   = 8,
  parameter logic [WIDTH-1:0]        PATTERN = 8'h52
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             out_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pat_q,   pat_d;
  logic [WIDTH-1:0] sh_q,    sh_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             out_q,   out_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // A Load coinciding with a frame start supplies that frame directly.
  logic [WIDTH-1:0] frame_val;
  logic [CW-1:0]    bit_idx;

  assign frame_val = load_i ? din_i : pat_q;
  assign bit_idx   = cnt_q - CW'(1);

  always_comb begin
    state_d = state_q;
    pat_d   = load_i ? din_i : pat_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        out_d  = 1'b0;
        busy_d = 1'b0;
        if (start_i) begin
          sh_d    = frame_val;
          out_d   = frame_val[WIDTH-1];
          cnt_d   = CW'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q != '0) begin
          // Mid-frame: Start is ignored, keep walking down the shift register.
          out_d = sh_q[bit_idx];
          cnt_d = bit_idx;
        end else begin
          // Last bit is on the wire now; this edge closes the frame.
          done_d = 1'b1;
          if (start_i) begin
            // Chain the next frame with no gap, Busy stays high.
            sh_d   = frame_val;
            out_d  = frame_val[WIDTH-1];
            cnt_d  = CW'(WIDTH - 1);
            busy_d = 1'b1;
          end else begin
            out_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        out_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pat_q   <= PATTERN;
      sh_q    <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_o  = out_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_seqgen_52.sv
// -----------------------------------------------------------------------------
// tb_seqgen_52 -- directed testbench for seqgen_52
//
// Outputs are checked as the triple {out, busy, done}, sampled 1 time unit
// after each rising clock edge. Inputs are changed right after sampling so
// they are stable well before the next edge.
// -----------------------------------------------------------------------------
module tb_seqgen_52;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       load;
  logic [7:0] din;
  logic       out_w;
  logic       busy_w;
  logic       done_w;

  int n_vec;
  int n_err;

  seqgen_52 #(.WIDTH(8), .PATTERN(8'h52)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .load_i  (load),
    .din_i   (din),
    .out_o   (out_w),
    .busy_o  (busy_w),
    .done_o  (done_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] expv);
    logic [2:0] obs;
    obs = {out_w, busy_w, done_w};
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed {out,busy,done}=%b expected %b", tag, obs, expv);
    end
  endtask

  // One complete frame starting from IDLE. Optional load at the start edge,
  // optional load of mid_val after bit 3 has been checked.
  task automatic frame(input string tag, input logic [7:0] expp,
                       input logic ld, input logic [7:0] d,
                       input logic mid_ld, input logic [7:0] mid_val);
    start = 1'b1;
    load  = ld;
    din   = d;
    tick();
    start = 1'b0;
    load  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      load = 1'b0;
      chk($sformatf("%s_bit%0d", tag, i), {expp[7-i], 1'b1, 1'b0});
      if (mid_ld && i == 3) begin
        load = 1'b1;
        din  = mid_val;
      end
    end
    tick();
    chk($sformatf("%s_done", tag), 3'b001);
    tick();
    chk($sformatf("%s_idle", tag), 3'b000);
  endtask

  initial begin
    logic [7:0] p;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    load  = 1'b0;
    din   = 8'h00;

    // Reset state, visible before any clock edge.
    #2;
    chk("reset_async", 3'b000);
    #5;
    rst_n = 1'b1;

    // Idle for 20 cycles with no request.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle%0d", i), 3'b000);
    end

    // Default pattern 0x52 -> 0,1,0,1,0,0,1,0.
    frame("f52", 8'h52, 1'b0, 8'h00, 1'b0, 8'h00);

    // Load 0xA5 while idle, then a plain Start.
    load = 1'b1;
    din  = 8'hA5;
    tick();
    load = 1'b0;
    chk("load_idle", 3'b000);
    frame("fA5", 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);

    // Load 0x3C at the same edge as Start: frame uses Din.
    frame("f3C", 8'h3C, 1'b1, 8'h3C, 1'b0, 8'h00);

    // Back to 0x52 via a load-with-start, then load 0xFF mid-frame.
    frame("f52b", 8'h52, 1'b1, 8'h52, 1'b1, 8'hFF);
    // Next frame sends eight 1s.
    frame("fFF", 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);

    // Restore 0x52 and run three back-to-back frames.
    load = 1'b1;
    din  = 8'h52;
    tick();
    load = 1'b0;
    chk("load52", 3'b000);
    p = 8'h52;
    start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        chk($sformatf("b2b_f%0d_b%0d", f, i),
            {p[7-i], 1'b1, (f > 0 && i == 0)});
        // Held through the third start; one stray pulse mid third frame.
        start = (f < 2) || (f == 1 && i == 7) || (f == 2 && i == 3);
      end
    end
    start = 1'b0;
    tick();
    chk("b2b_done", 3'b001);
    tick();
    chk("b2b_idle", 3'b000);

    // Async reset mid-frame. Frame uses 0xF0 (also loaded into pat).
    p = 8'hF0;
    start = 1'b1;
    load  = 1'b1;
    din   = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
      load  = 1'b0;
      chk($sformatf("rst_frame_b%0d", i), {p[7-i], 1'b1, 1'b0});
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async", 3'b000);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_idle%0d", i), 3'b000);
    end
    // Pattern register back at its reset value.
    frame("post_rst", 8'h52, 1'b0, 8'h00, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
